// File: rtl/axi_mem_responder.sv
// axi_mem_responder: AXI4 slave with a 512-bit line memory; independent read and write FSMs; SLVERR for out-of-range beats; ports: clk, rst, AR/R/AW/W/B channels (suffix _s).
module axi_mem_responder #(
  parameter int LOG_DEPTH = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [15:0]  arid_s,
  input  logic [63:0]  araddr_s,
  input  logic [7:0]   arlen_s,
  input  logic [2:0]   arsize_s,
  input  logic         arvalid_s,
  output logic         arready_s,
  output logic [15:0]  rid_s,
  output logic [511:0] rdata_s,
  output logic [1:0]   rresp_s,
  output logic         rlast_s,
  output logic         rvalid_s,
  input  logic         rready_s,
  input  logic [15:0]  awid_s,
  input  logic [63:0]  awaddr_s,
  input  logic [7:0]   awlen_s,
  input  logic [2:0]   awsize_s,
  input  logic         awvalid_s,
  output logic         awready_s,
  input  logic [511:0] wdata_s,
  input  logic [63:0]  wstrb_s,
  input  logic         wlast_s,
  input  logic         wvalid_s,
  output logic         wready_s,
  output logic [15:0]  bid_s,
  output logic [1:0]   bresp_s,
  output logic         bvalid_s,
  input  logic         bready_s
);
  localparam int LINES = 1 << LOG_DEPTH;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  logic [511:0] mem [LINES];
  r_state_e r_state_q, r_state_d;
  w_state_e w_state_q, w_state_d;
  logic [15:0] rid_q, wid_q;
  logic [58:0] rline_q, rline_d, wline_q;
  logic [7:0] rlen_q, rcnt_q, wlen_q, wcnt_q;
  logic [511:0] rdata_q;
  logic [1:0] rresp_q;
  logic werr_q;
  logic ar_hs, r_hs, r_last, r_load, r_oor;
  logic aw_hs, w_hs, w_last, w_oor, w_we, b_hs;
  logic unused;
  assign unused = ^{arsize_s, awsize_s, araddr_s[5:0], awaddr_s[5:0]};
  // Line addresses carry one spare bit so line + 255 never wraps back into range.
  assign ar_hs = arvalid_s & arready_s;
  assign r_hs = rvalid_s & rready_s;
  assign r_last = rcnt_q == rlen_q;
  assign r_load = ar_hs | (r_hs & !r_last);
  assign rline_d = ar_hs ? {1'b0, araddr_s[63:6]} : rline_q + 59'd1;
  assign r_oor = |rline_d[58:LOG_DEPTH];
  assign aw_hs = awvalid_s & awready_s;
  assign w_hs = wvalid_s & wready_s;
  assign w_last = wcnt_q == wlen_q;
  assign w_oor = |wline_q[58:LOG_DEPTH];
  assign w_we = w_hs & !w_oor;
  assign b_hs = bvalid_s & bready_s;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      rid_q <= '0;
      rline_q <= '0;
      rlen_q <= '0;
      rcnt_q <= '0;
      rresp_q <= '0;
      w_state_q <= W_IDLE;
      wid_q <= '0;
      wline_q <= '0;
      wlen_q <= '0;
      wcnt_q <= '0;
      werr_q <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      w_state_q <= w_state_d;
      if (ar_hs) begin
        rid_q <= arid_s;
        rlen_q <= arlen_s;
        rcnt_q <= '0;
      end else if (r_hs) rcnt_q <= rcnt_q + 8'd1;
      if (r_load) begin
        rline_q <= rline_d;
        rresp_q <= r_oor ? 2'b10 : 2'b00;
      end
      if (aw_hs) begin
        wid_q <= awid_s;
        wline_q <= {1'b0, awaddr_s[63:6]};
        wlen_q <= awlen_s;
        wcnt_q <= '0;
        werr_q <= 1'b0;
      end else if (w_hs) begin
        wline_q <= wline_q + 59'd1;
        wcnt_q <= wcnt_q + 8'd1;
        werr_q <= werr_q | w_oor | (wlast_s != w_last);
      end
    end
  end
  // Read data is registered when a beat is launched, so a same-cycle write sees the old line and a stalled beat never changes.
  always_ff @(posedge clk) begin
    if (r_load) rdata_q <= r_oor ? '0 : mem[rline_d[LOG_DEPTH-1:0]];
    if (w_we)
      for (int i = 0; i < 64; i++)
        if (wstrb_s[i]) mem[wline_q[LOG_DEPTH-1:0]][8*i +: 8] <= wdata_s[8*i +: 8];
  end
  always_comb begin
    r_state_d = ar_hs ? R_DATA : (r_hs & r_last) ? R_IDLE : r_state_q;
    w_state_d = aw_hs ? W_DATA : (w_hs & w_last) ? W_RESP : b_hs ? W_IDLE : w_state_q;
  end
  // Handshake and response outputs are masked while rst is high so nothing escapes during the reset cycle.
  always_comb begin
    arready_s = !rst & (r_state_q == R_IDLE);
    rvalid_s = !rst & (r_state_q == R_DATA);
    rlast_s = rvalid_s & r_last;
    rid_s = rst ? '0 : rid_q;
    rresp_s = rst ? '0 : rresp_q;
    rdata_s = rdata_q;
    awready_s = !rst & (w_state_q == W_IDLE);
    wready_s = !rst & (w_state_q == W_DATA);
    bvalid_s = !rst & (w_state_q == W_RESP);
    bid_s = rst ? '0 : wid_q;
    bresp_s = bvalid_s ? {werr_q, 1'b0} : 2'b00;
  end
endmodule

// File: tb/tb_axi_mem_responder.sv
// tb_axi_mem_responder: scoreboard bench for axi_mem_responder.
module tb_axi_mem_responder;
  localparam int LD = 10;
  localparam int LINES = 1 << LD;
  logic clk, rst;
  logic [15:0] arid_s, rid_s, awid_s, bid_s;
  logic [63:0] araddr_s, awaddr_s, wstrb_s;
  logic [7:0] arlen_s, awlen_s;
  logic [2:0] arsize_s, awsize_s;
  logic arvalid_s, arready_s, rlast_s, rvalid_s, rready_s;
  logic awvalid_s, awready_s, wlast_s, wvalid_s, wready_s, bvalid_s, bready_s;
  logic [511:0] rdata_s, wdata_s;
  logic [1:0] rresp_s, bresp_s;
  typedef struct {logic [511:0] d; logic [1:0] resp; logic last; logic [15:0] id;} rexp_t;
  rexp_t rq[$];
  logic [17:0] bq[$];
  logic [511:0] mdl [LINES];
  int checks = 0, errors = 0, rseen = 0, bseen = 0;
  logic rhold = 0;
  logic [511:0] hd;
  logic [18:0] hc;
  rexp_t re;
  logic [17:0] be;

  axi_mem_responder #(.LOG_DEPTH(LD)) dut (
    .clk(clk), .rst(rst),
    .arid_s(arid_s), .araddr_s(araddr_s), .arlen_s(arlen_s), .arsize_s(arsize_s),
    .arvalid_s(arvalid_s), .arready_s(arready_s),
    .rid_s(rid_s), .rdata_s(rdata_s), .rresp_s(rresp_s), .rlast_s(rlast_s),
    .rvalid_s(rvalid_s), .rready_s(rready_s),
    .awid_s(awid_s), .awaddr_s(awaddr_s), .awlen_s(awlen_s), .awsize_s(awsize_s),
    .awvalid_s(awvalid_s), .awready_s(awready_s),
    .wdata_s(wdata_s), .wstrb_s(wstrb_s), .wlast_s(wlast_s), .wvalid_s(wvalid_s),
    .wready_s(wready_s),
    .bid_s(bid_s), .bresp_s(bresp_s), .bvalid_s(bvalid_s), .bready_s(bready_s)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] bd(input logic [31:0] s, input int n);
    return {16{s + 32'(n)}};
  endfunction

  always @(negedge clk) begin
    if (!rst && rvalid_s) begin
      if (rhold) begin
        chk("r_stable_data", rdata_s, hd);
        chk("r_stable_ctl", {rid_s, rresp_s, rlast_s}, hc);
      end
      if (rready_s) begin
        rhold = 0;
        rseen++;
        chk("r_pending", rq.size() != 0, 1);
        if (rq.size() != 0) begin
          re = rq.pop_front();
          chk("rdata", rdata_s, re.d);
          chk("rresp", rresp_s, re.resp);
          chk("rlast", rlast_s, re.last);
          chk("rid", rid_s, re.id);
        end
      end else begin
        rhold = 1;
        hd = rdata_s;
        hc = {rid_s, rresp_s, rlast_s};
      end
    end else rhold = 0;
    if (!rst && bvalid_s && bready_s) begin
      bseen++;
      chk("b_pending", bq.size() != 0, 1);
      if (bq.size() != 0) begin
        be = bq.pop_front();
        chk("bid", bid_s, be[17:2]);
        chk("bresp", bresp_s, be[1:0]);
      end
    end
  end

  task automatic hs(input int which);
    int c;
    for (c = 0; c < 100; c++) begin
      @(negedge clk);
      if ((which == 0) ? arready_s : (which == 1) ? awready_s : wready_s) break;
    end
    chk("hs_timeout", c < 100, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] id, input logic [63:0] addr, input logic [7:0] len,
                    input logic [63:0] strb, input logic [31:0] seed, input int lb);
    logic [63:0] l;
    logic [511:0] d;
    logic err;
    int c, target;
    err = 0;
    for (int n = 0; n <= int'(len); n++) begin
      l = (addr >> 6) + 64'(n);
      d = bd(seed, n);
      err |= (l >= LINES) | ((n == lb) != (n == int'(len)));
      if (l < LINES)
        for (int i = 0; i < 64; i++)
          if (strb[i]) mdl[l[LD-1:0]][8*i +: 8] = d[8*i +: 8];
    end
    bq.push_back({id, err, 1'b0});
    target = bseen + 1;
    awid_s = id; awaddr_s = addr; awlen_s = len; awvalid_s = 1;
    hs(1);
    awvalid_s = 0;
    for (int n = 0; n <= int'(len); n++) begin
      wdata_s = bd(seed, n); wstrb_s = strb; wlast_s = (n == lb); wvalid_s = 1;
      hs(2);
    end
    wvalid_s = 0; wlast_s = 0; bready_s = 1;
    for (c = 0; c < 100 && bseen < target; c++) begin
      @(posedge clk);
      #1;
    end
    chk("b_timeout", bseen >= target, 1);
    bready_s = 0;
  endtask

  task automatic rd(input logic [15:0] id, input logic [63:0] addr, input logic [7:0] len, input bit tog);
    logic [63:0] l;
    rexp_t e;
    int c, target;
    for (int n = 0; n <= int'(len); n++) begin
      l = (addr >> 6) + 64'(n);
      e.d = (l >= LINES) ? '0 : mdl[l[LD-1:0]];
      e.resp = (l >= LINES) ? 2'b10 : 2'b00;
      e.last = (n == int'(len));
      e.id = id;
      rq.push_back(e);
    end
    target = rseen + int'(len) + 1;
    arid_s = id; araddr_s = addr; arlen_s = len; arvalid_s = 1;
    hs(0);
    arvalid_s = 0; rready_s = 1;
    @(negedge clk);
    chk("r_latency", rvalid_s, 1);
    c = 0;
    do begin
      @(posedge clk);
      #1;
      if (tog) rready_s = ~rready_s;
      c++;
    end while (rseen < target && c < 200);
    chk("r_timeout", rseen >= target, 1);
    rready_s = 0;
  endtask

  initial begin
    rst = 1;
    {arid_s, araddr_s, arlen_s, arsize_s, arvalid_s, rready_s} = '0;
    {awid_s, awaddr_s, awlen_s, awsize_s, awvalid_s} = '0;
    {wdata_s, wstrb_s, wlast_s, wvalid_s, bready_s} = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_arready", arready_s, 0);
    chk("rst_awready", awready_s, 0);
    chk("rst_wready", wready_s, 0);
    chk("rst_rvalid", rvalid_s, 0);
    chk("rst_bvalid", bvalid_s, 0);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("post_rst_ids", {rid_s, bid_s, rresp_s, bresp_s, rlast_s}, 0);
    chk("post_rst_ready", {arready_s, awready_s}, 2'b11);
    @(posedge clk);
    #1;
    wr(7, 64'hC0, 0, '1, 32'hA5A5A5A5, 0);
    rd(5, 64'hC0, 0, 0);
    wr(1, 64'h0, 2, '1, 32'h10000000, 2);
    rd(2, 64'h0, 3, 1);
    wr(3, 64'hC0, 0, 64'h0F, 32'h3C3C3C3C, 0);
    rd(4, 64'hC0, 0, 0);
    rd(6, 64'h8000_0000_0000_0000, 0, 0);
    wr(8, 64'h8000_0000_0000_0040, 0, '1, 32'h12345678, 0);
    wr(9, 64'(LINES - 1) * 64, 0, '1, 32'hDEAD0000, 0);
    rd(10, 64'(LINES - 1) * 64, 1, 1);
    wr(11, 64'h100, 1, '1, 32'h55550000, 0);
    chk("aw_ready_after_bad_wlast", awready_s, 1);
    rd(12, 64'h100, 1, 0);
    arid_s = 16'h99; araddr_s = 0; arlen_s = 3; arvalid_s = 1;
    hs(0);
    arvalid_s = 0;
    @(negedge clk);
    chk("rst_pre_rvalid", rvalid_s, 1);
    @(posedge clk);
    #1 rst = 1;
    @(negedge clk);
    chk("rst_mid_rvalid", rvalid_s, 0);
    chk("rst_mid_arready", arready_s, 0);
    chk("rst_mid_rid", {rid_s, rresp_s}, 0);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_rel_arready", arready_s, 1);
    chk("rst_rel_rvalid", rvalid_s, 0);
    @(posedge clk);
    #1;
    rd(13, 64'hC0, 0, 0);
    rd(14, 64'h0, 2, 1);
    chk("rq_drained", rq.size(), 0);
    chk("bq_drained", bq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_mem_responder.md
AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

Interface
REQ-001 LOG_DEPTH, default 10, log2 of memory depth in 64-byte lines; LINES = 2^LOG_DEPTH.
REQ-002 clk  in  1  sole clock; all logic on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 arid_s  in  16  read transaction ID.
REQ-005 araddr_s  in  64  read byte address; bits [5:0] ignored.
REQ-006 arlen_s  in  8  read burst length minus one.
REQ-007 arsize_s  in  3  ignored; every beat is a full 512-bit line.
REQ-008 arvalid_s  in  1  read address valid.
REQ-009 arready_s  out  1  read address accepted.
REQ-010 rid_s  out  16  ID of current read burst.
REQ-011 rdata_s  out  512  read line data.
REQ-012 rresp_s  out  2  2'b00 OKAY, 2'b10 SLVERR.
REQ-013 rlast_s  out  1  final beat of burst.
REQ-014 rvalid_s  out  1  read data valid.
REQ-015 rready_s  in  1  master accepts read beat.
REQ-016 awid_s  in  16  write transaction ID.
REQ-017 awaddr_s  in  64  write byte address; bits [5:0] ignored.
REQ-018 awlen_s  in  8  write burst length minus one.
REQ-019 awsize_s  in  3  ignored.
REQ-020 awvalid_s  in  1  write address valid.
REQ-021 awready_s  out  1  write address accepted.
REQ-022 wdata_s  in  512  write line data.
REQ-023 wstrb_s  in  64  per-byte write enable; bit i covers wdata_s[8i+7:8i].
REQ-024 wlast_s  in  1  master marks final write beat.
REQ-025 wvalid_s  in  1  write data valid.
REQ-026 wready_s  out  1  write beat accepted.
REQ-027 bid_s  out  16  ID of completed write burst.
REQ-028 bresp_s  out  2  2'b00 OKAY, 2'b10 SLVERR.
REQ-029 bvalid_s  out  1  write response valid.
REQ-030 bready_s  in  1  master accepts write response.

Function
REQ-031 Line index = addr[LOG_DEPTH+5:6]; addr[63:LOG_DEPTH+6] nonzero = out of range; beat N of a burst uses line address + N (INCR, no wrap; overflow past LINES counts out of range).
REQ-032 Read FSM R_IDLE/R_DATA: arready_s=1 only in R_IDLE; AR handshake latches id/addr/len, next cycle R_DATA with rvalid_s=1 (1-cycle latency).
REQ-033 Each R handshake advances address and beat count; rlast_s=1 iff count==len; handshake on last beat -> R_IDLE, arready_s high next cycle.
REQ-034 rid_s/rdata_s/rresp_s/rlast_s held stable while rvalid_s & !rready_s.
REQ-035 Out-of-range read beat: rdata_s=0, rresp_s=2'b10; in-range: memory line, 2'b00.
REQ-036 Write FSM W_IDLE/W_DATA/W_RESP: awready_s=1 only in W_IDLE; AW handshake latches id/addr/len -> W_DATA; wready_s=1 only in W_DATA.
REQ-037 Each W handshake writes only strobed bytes of in-range line; out-of-range beats dropped; beat count (not wlast_s) ends burst -> W_RESP.
REQ-038 W_RESP: bvalid_s=1, bid_s=latched id; bresp_s=2'b10 if any beat out of range or wlast_s disagreed with count==len on any beat, else 2'b00; B handshake -> W_IDLE.
REQ-039 Read and write channels independent and concurrent; same-line read beat and write beat in one cycle returns pre-write data (read-before-write).

Reset
REQ-040 rst: both FSMs to IDLE; arready_s, awready_s, wready_s, rvalid_s, rlast_s, bvalid_s = 0, rid_s/bid_s/rresp_s/bresp_s = 0 during and first cycle after rst; in-flight bursts abandoned without response; memory contents retained.

Verification
REQ-041 Write line 3 (awaddr 0xC0, awlen 0, wstrb all ones, data 0xA5 pattern), then read 0xC0 -> bresp 00, rdata 0xA5 pattern, rlast 1, rid echoes arid 5.
REQ-042 Read burst araddr 0x0, arlen 3, rready toggled every cycle -> 4 beats lines 0..3, rlast only on 4th, data stable while stalled.
REQ-043 Write wstrb 0x0F to line with prior all-ones -> only bytes 0..3 updated on readback; araddr with bit 63 set -> rdata 0, rresp 10.
REQ-044 Write awlen 1 with wlast on beat 0 -> bresp 10, two beats consumed; assert rst during read burst -> rvalid_s 0 next cycle, arready_s 1 after release.
